cv32e40x_wb_stage: RTL

Writeback stage: the consumer end of the EX/WB pipeline handshake. Accepts one instruction per cycle from EX and back-pressures EX via `wb_ready_o`. Holds each load until its LSU response arrives, then aligns and sign-extends the returned data. Performs the single register-file write and provides WB-stage forwarding to ID.

---
 rtl/cv32e40x_pkg.sv | 18 +
 rtl/cv32e40x_load_align.sv | 38 +++
 rtl/cv32e40x_wb_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x EX/WB pipeline boundary.
package cv32e40x_pkg;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        lsu_en;
        logic [1:0]  lsu_size;
        logic        lsu_sext;
        logic [1:0]  lsu_addr_lo;
    } ex_wb_pipe_t;

endpackage

// File: rtl/cv32e40x_load_align.sv
// Combinational load data aligner: extracts the addressed byte/half/word
// from a word-aligned bus beat and zero- or sign-extends it.
module cv32e40x_load_align
    import cv32e40x_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        wdata_o  = rdata_i;

        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        // Misaligned halves are split upstream, so only addr_lo[1] matters.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            LSU_SIZE_BYTE: wdata_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            LSU_SIZE_HALF: wdata_o = {{16{sext_i & half_sel[15]}}, half_sel};
            default:       wdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/cv32e40x_wb_stage.sv
// Writeback stage: holds one instruction from EX, waits for load responses,
// performs the register-file write and drives the WB forwarding outputs.
module cv32e40x_wb_stage
    import cv32e40x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid_i,
    input  ex_wb_pipe_t ex_wb_pipe_i,
    output logic        wb_ready_o,

    input  logic        lsu_rvalid_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        lsu_err_i,

    output logic        rf_we_wb_o,
    output logic [4:0]  rf_waddr_wb_o,
    output logic [31:0] rf_wdata_wb_o,

    output logic        wb_valid_o,
    output logic        wb_err_o,
    output logic        wb_busy_o
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ALU       = 2'd1,
        LOAD_WAIT = 2'd2
    } wb_state_e;

    wb_state_e   state_q, state_d;
    ex_wb_pipe_t entry_q, entry_d;

    logic        done;
    logic        accept;
    logic        load_resp;
    logic [31:0] load_wdata;

    cv32e40x_load_align u_load_align (
        .size_i    (entry_q.lsu_size),
        .sext_i    (entry_q.lsu_sext),
        .addr_lo_i (entry_q.lsu_addr_lo),
        .rdata_i   (lsu_rdata_i),
        .wdata_o   (load_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // Outputs are gated by rst so everything except ready reads 0 while
    // reset is held, even in the cycle before the reset edge.
    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        load_resp     = (state_q == LOAD_WAIT) && lsu_rvalid_i;
        done          = !rst && ((state_q == ALU) || load_resp);
        wb_ready_o    = (state_q == EMPTY) || done;
        accept        = !rst && ex_valid_i && wb_ready_o;

        rf_we_wb_o    = done && entry_q.rf_we && (entry_q.rf_waddr != 5'd0) &&
                        !(load_resp && lsu_err_i);
        rf_waddr_wb_o = rst ? 5'd0 : entry_q.rf_waddr;
        rf_wdata_wb_o = rst ? 32'd0 :
                        (state_q == LOAD_WAIT) ? load_wdata : entry_q.rf_wdata;
        wb_valid_o    = done;
        wb_err_o      = !rst && load_resp && lsu_err_i;
        wb_busy_o     = !rst && (state_q != EMPTY);

        if (accept) begin
            entry_d = ex_wb_pipe_i;
            state_d = ex_wb_pipe_i.lsu_en ? LOAD_WAIT : ALU;
        end else if (done) begin
            state_d = EMPTY;
        end
    end

endmodule
